// File: rtl/bsg_manycore_vcache_wh_pkg.sv
// Shared vcache DMA wormhole types: request header layout and memory endpoint FSM states.
package bsg_manycore_vcache_wh_pkg;

  localparam int wh_flit_width_gp     = 32;
  localparam int wh_cord_width_gp     = 4;
  localparam int wh_len_width_gp      = 3;
  localparam int wh_cid_width_gp      = 2;
  localparam int vcache_addr_width_gp = 14;

  localparam int wh_hdr_used_width_gp = 2*wh_cord_width_gp + wh_len_width_gp
                                      + 2*wh_cid_width_gp + 1 + vcache_addr_width_gp;
  localparam int wh_hdr_pad_width_gp  = wh_flit_width_gp - wh_hdr_used_width_gp;

  // Declared MSB first, so cord sits at bit 0.
  typedef struct packed {
    logic [wh_hdr_pad_width_gp-1:0]  pad;
    logic [vcache_addr_width_gp-1:0] addr;
    logic [wh_cid_width_gp-1:0]      src_cid;
    logic [wh_cord_width_gp-1:0]     src_cord;
    logic                            write_not_read;
    logic [wh_cid_width_gp-1:0]      cid;
    logic [wh_len_width_gp-1:0]      len;
    logic [wh_cord_width_gp-1:0]     cord;
  } bsg_manycore_vcache_wh_req_header_s;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_DATA = 2'd1,
    SEND_HDR   = 2'd2,
    SEND_DATA  = 2'd3
  } vcache_wh_mem_state_e;

  // Link layout is {v, ready_and_rev, data}.
  function automatic int bsg_ready_and_link_sif_width(input int flit_width);
    return flit_width + 2;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Register-array memory: synchronous write, combinational read, contents not reset.
module bsg_mem_1r1w #(
  parameter int width_p = 32,
  parameter int els_p = 1024,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     i_clk,
  input  logic                     i_w_v,
  input  logic [addr_width_lp-1:0] i_w_addr,
  input  logic [width_p-1:0]       i_w_dat,
  input  logic [addr_width_lp-1:0] i_r_addr,
  output logic [width_p-1:0]       o_r_dat
);

  logic [width_p-1:0] r_mem [els_p];

  always_ff @(posedge i_clk) begin
    if (i_w_v) r_mem[i_w_addr] <= i_w_dat;
  end

  assign o_r_dat = r_mem[i_r_addr];

endmodule

// File: rtl/bsg_manycore_vcache_wh_mem_responder.sv
// Wormhole memory endpoint: writes consume 1 flit/cycle; a read header answers one cycle later with
// a header plus one block of flits. Request ready drops while a response is outstanding.
module bsg_manycore_vcache_wh_mem_responder
  import bsg_manycore_vcache_wh_pkg::*;
#(
  parameter int wh_flit_width_p              = wh_flit_width_gp,
  parameter int wh_cord_width_p              = wh_cord_width_gp,
  parameter int wh_len_width_p               = wh_len_width_gp,
  parameter int wh_cid_width_p               = wh_cid_width_gp,
  parameter int vcache_addr_width_p          = vcache_addr_width_gp,
  parameter int vcache_data_width_p          = 32,
  parameter int vcache_block_size_in_words_p = 4,
  parameter int mem_els_p                    = 1024,
  localparam int wh_link_sif_width_lp        = bsg_ready_and_link_sif_width(wh_flit_width_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [wh_link_sif_width_lp-1:0] wh_link_sif_i,
  output logic [wh_link_sif_width_lp-1:0] wh_link_sif_o
);

  localparam int flits_per_block_lp =
    vcache_block_size_in_words_p * vcache_data_width_p / wh_flit_width_p;
  localparam int lg_els_lp     = $clog2(mem_els_p);
  localparam int byte_shift_lp = $clog2(wh_flit_width_p/8);
  localparam int hdr_bits_lp   = 2*wh_cord_width_p + wh_len_width_p + 2*wh_cid_width_p + 1
                               + vcache_addr_width_p;
  localparam logic [wh_len_width_p-1:0] fpb_len_lp = wh_len_width_p'(flits_per_block_lp);

  if (hdr_bits_lp > wh_flit_width_p) begin : g_chk_hdr_fit
    $error("request header does not fit in a flit");
  end
  if (wh_flit_width_p != wh_flit_width_gp || wh_cord_width_p != wh_cord_width_gp
      || wh_len_width_p != wh_len_width_gp || wh_cid_width_p != wh_cid_width_gp
      || vcache_addr_width_p != vcache_addr_width_gp) begin : g_chk_hdr_layout
    $error("widths must match the shared header struct");
  end
  if (flits_per_block_lp < 1 || flits_per_block_lp * wh_flit_width_p
      != vcache_block_size_in_words_p * vcache_data_width_p) begin : g_chk_fpb
    $error("block size must be a whole number of flits");
  end
  if (flits_per_block_lp >= (1 << wh_len_width_p)) begin : g_chk_fpb_len
    $error("block flit count does not fit in the len field");
  end
  if (mem_els_p < 2 || (1 << lg_els_lp) != mem_els_p
      || vcache_addr_width_p < lg_els_lp) begin : g_chk_els
    $error("mem_els_p must be a power of 2 addressable by the header");
  end

  logic                          w_in_v, w_out_rdy, w_in_rdy, w_out_v, w_mem_we;
  logic [wh_flit_width_p-1:0]    w_in_dat, w_out_dat, w_mem_r_dat;
  logic [vcache_addr_width_p-1:0] w_hdr_flit_addr;
  logic [lg_els_lp-1:0]          r_idx, w_idx_n, w_hdr_idx;
  logic [wh_len_width_p-1:0]     r_cnt, w_cnt_n;
  logic [wh_cord_width_p-1:0]    r_src_cord, w_src_cord_n;
  logic [wh_cid_width_p-1:0]     r_src_cid, w_src_cid_n;
  vcache_wh_mem_state_e          r_state, w_state_n;
  bsg_manycore_vcache_wh_req_header_s w_in_hdr, w_rsp_hdr;
  logic                          w_unused;

  assign {w_in_v, w_out_rdy, w_in_dat} = wh_link_sif_i;
  assign wh_link_sif_o = {w_out_v, w_in_rdy, w_out_dat};

  assign w_in_hdr        = w_in_dat;
  assign w_hdr_flit_addr = w_in_hdr.addr >> byte_shift_lp;
  assign w_hdr_idx       = w_hdr_flit_addr[lg_els_lp-1:0];
  assign w_unused        = ^{w_in_hdr.pad, w_in_hdr.cord, w_in_hdr.cid, w_hdr_flit_addr};

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_idx_n      = r_idx;
    w_src_cord_n = r_src_cord;
    w_src_cid_n  = r_src_cid;
    w_in_rdy     = 1'b0;
    w_out_v      = 1'b0;
    w_out_dat    = '0;
    w_mem_we     = 1'b0;
    w_rsp_hdr          = '0;
    w_rsp_hdr.cord     = r_src_cord;
    w_rsp_hdr.len      = fpb_len_lp;
    w_rsp_hdr.cid      = r_src_cid;

    // Handshakes are masked during reset so a mid-packet reset writes nothing.
    case (r_state)
      IDLE: begin
        w_in_rdy = ~reset_i;
        if (w_in_v && w_in_rdy) begin
          w_idx_n = w_hdr_idx;
          if (w_in_hdr.write_not_read) begin
            w_cnt_n = w_in_hdr.len;
            if (w_in_hdr.len != '0) w_state_n = WRITE_DATA;
          end else begin
            w_src_cord_n = w_in_hdr.src_cord;
            w_src_cid_n  = w_in_hdr.src_cid;
            w_state_n    = SEND_HDR;
          end
        end
      end
      WRITE_DATA: begin
        w_in_rdy = ~reset_i;
        if (w_in_v && w_in_rdy) begin
          w_mem_we = 1'b1;
          w_idx_n  = r_idx + lg_els_lp'(1);
          w_cnt_n  = r_cnt - wh_len_width_p'(1);
          if (r_cnt == wh_len_width_p'(1)) w_state_n = IDLE;
        end
      end
      SEND_HDR: begin
        w_out_v   = ~reset_i;
        w_out_dat = w_out_v ? wh_flit_width_p'(w_rsp_hdr) : '0;
        if (w_out_v && w_out_rdy) begin
          w_cnt_n   = fpb_len_lp;
          w_state_n = SEND_DATA;
        end
      end
      SEND_DATA: begin
        w_out_v   = ~reset_i;
        w_out_dat = w_out_v ? w_mem_r_dat : '0;
        if (w_out_v && w_out_rdy) begin
          w_idx_n = r_idx + lg_els_lp'(1);
          w_cnt_n = r_cnt - wh_len_width_p'(1);
          if (r_cnt == wh_len_width_p'(1)) w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_src_cord <= '0;
      r_src_cid  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_src_cord <= w_src_cord_n;
      r_src_cid  <= w_src_cid_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p(wh_flit_width_p),
    .els_p  (mem_els_p)
  ) mem (
    .i_clk   (clk_i),
    .i_w_v   (w_mem_we),
    .i_w_addr(r_idx),
    .i_w_dat (w_in_dat),
    .i_r_addr(r_idx),
    .o_r_dat (w_mem_r_dat)
  );

endmodule

// File: tb/tb_bsg_manycore_vcache_wh_mem_responder.sv
// Cycle-vector bench for the wormhole memory responder, plus a randomly backpressured read.
module tb_bsg_manycore_vcache_wh_mem_responder;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_v = 1'b0;
  logic out_rdy = 1'b1;
  logic [W-1:0] in_dat = '0;
  logic [W+1:0] sif_i, sif_o;
  logic o_v, o_rdy;
  logic [W-1:0] o_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sif_i = {in_v, out_rdy, in_dat};
  assign {o_v, o_rdy, o_dat} = sif_o;

  bsg_manycore_vcache_wh_mem_responder #(
    .wh_flit_width_p(32), .wh_cord_width_p(4), .wh_len_width_p(3), .wh_cid_width_p(2),
    .vcache_addr_width_p(14), .vcache_data_width_p(32), .vcache_block_size_in_words_p(4),
    .mem_els_p(16)
  ) dut (
    .clk_i(clk), .reset_i(rst), .wh_link_sif_i(sif_i), .wh_link_sif_o(sif_o)
  );

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] idat;
    logic         ordy;
    logic         ev;
    logic [W-1:0] edat;
    logic         erdy;
  } vec_t;

  vec_t vecs[$];

  // Header fields LSB first: cord[3:0] len[6:4] cid[8:7] wnr[9] src_cord[13:10] src_cid[15:14] addr[29:16]
  function automatic logic [W-1:0] mk_hdr(int cord, int len, int cid, int wnr,
                                          int scord, int scid, int addr);
    logic [W-1:0] h;
    h = 32'(cord) & 32'hF;
    h = h | ((32'(len)   & 32'h7)    << 4);
    h = h | ((32'(cid)   & 32'h3)    << 7);
    h = h | ((32'(wnr)   & 32'h1)    << 9);
    h = h | ((32'(scord) & 32'hF)    << 10);
    h = h | ((32'(scid)  & 32'h3)    << 14);
    h = h | ((32'(addr)  & 32'h3FFF) << 16);
    return h;
  endfunction

  function automatic logic [W-1:0] wr(int addr, int len);
    return mk_hdr(1, len, 1, 1, 5, 2, addr);
  endfunction

  // Read len is deliberately nonzero and wrong; the response must still be a full block.
  function automatic logic [W-1:0] rd(int addr);
    return mk_hdr(1, 7, 1, 0, 5, 2, addr);
  endfunction

  localparam logic [W-1:0] RSP  = 32'h0000_0145;  // cord=5, len=4, cid=2
  localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

  task automatic add(input logic r, input logic iv, input logic [W-1:0] idat, input logic ordy,
                     input logic ev, input logic [W-1:0] edat, input logic erdy);
    vec_t v;
    v.rst = r; v.iv = iv; v.idat = idat; v.ordy = ordy;
    v.ev = ev; v.edat = edat; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic add_idle();
    add(0, 0, '0, 1, 0, '0, 1);
  endtask

  task automatic add_write(input int addr, input logic [W-1:0] base);
    add(0, 1, wr(addr, 4), 1, 0, '0, 1);
    for (int k = 0; k < 4; k++) add(0, 1, base + 32'(k), 1, 0, '0, 1);
  endtask

  task automatic add_rsp(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input logic [W-1:0] d3, input logic iv, input logic [W-1:0] idat);
    add(0, iv, idat, 1, 1, RSP, 0);
    add(0, iv, idat, 1, 1, d0, 0);
    add(0, iv, idat, 1, 1, d1, 0);
    add(0, iv, idat, 1, 1, d2, 0);
    add(0, iv, idat, 1, 1, d3, 0);
  endtask

  logic [W-1:0] hs_exp [5];
  int got;
  int cyc;

  initial begin
    // Reset state, then ready on the first cycle after deassertion.
    add(1, 0, '0, 1, 0, '0, 0);
    add(1, 1, JUNK, 1, 0, '0, 0);
    add_idle();

    // Block write at 0x40 (index 16 mod 16 = 0) and readback; header accepted right after last data.
    add_write('h40, 32'hA0);
    add(0, 1, rd('h40), 1, 0, '0, 1);
    add_rsp(32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, JUNK);
    add_idle();

    // Backpressure for 5 cycles on data flit 2.
    add(0, 1, rd('h40), 1, 0, '0, 1);
    add(0, 0, '0, 1, 1, RSP, 0);
    add(0, 0, '0, 1, 1, 32'hA0, 0);
    add(0, 0, '0, 1, 1, 32'hA1, 0);
    for (int k = 0; k < 5; k++) add(0, 1, JUNK, 0, 1, 32'hA2, 0);
    add(0, 0, '0, 1, 1, 32'hA2, 0);
    add(0, 0, '0, 1, 1, 32'hA3, 0);
    add_idle();

    // Write at index 14 wraps to 0,1; index 2,3 keep A2,A3.
    add_write('h38, 32'hB0);
    add(0, 1, rd('h38), 1, 0, '0, 1);
    add_rsp(32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, '0);
    add(0, 1, rd('h00), 1, 0, '0, 1);
    add_rsp(32'hB2, 32'hB3, 32'hA2, 32'hA3, 0, '0);

    // Zero-length write: stays idle, next header taken the next cycle, no response for it.
    add(0, 1, wr('h20, 0), 1, 0, '0, 1);
    add(0, 1, rd('h40), 1, 0, '0, 1);
    add_rsp(32'hB2, 32'hB3, 32'hA2, 32'hA3, 0, '0);
    add_idle();

    // Back-to-back reads with request valid held high.
    add(0, 1, rd('h38), 1, 0, '0, 1);
    add_rsp(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1, rd('h00));
    add(0, 1, rd('h00), 1, 0, '0, 1);
    add_rsp(32'hB2, 32'hB3, 32'hA2, 32'hA3, 0, '0);
    add_idle();

    // Reset after 2 of 4 write flits: written flits persist, partial packet dropped.
    add_write('h10, 32'hD0);
    add(0, 1, wr('h10, 4), 1, 0, '0, 1);
    add(0, 1, 32'hC0, 1, 0, '0, 1);
    add(0, 1, 32'hC1, 1, 0, '0, 1);
    add(1, 1, 32'hC2, 1, 0, '0, 0);
    add(0, 1, rd('h10), 1, 0, '0, 1);
    add_rsp(32'hC0, 32'hC1, 32'hD2, 32'hD3, 0, '0);
    add_idle();
    add_idle();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_v = vecs[i].iv; in_dat = vecs[i].idat; out_rdy = vecs[i].ordy;
      #1;
      checks++;
      if (o_v !== vecs[i].ev || o_dat !== vecs[i].edat || o_rdy !== vecs[i].erdy) begin
        errors++;
        $display("FAIL vec[%0d]: got v=%0b dat=%h rdy=%0b, expected v=%0b dat=%h rdy=%0b",
                 i, o_v, o_dat, o_rdy, vecs[i].ev, vecs[i].edat, vecs[i].erdy);
      end
    end

    // Randomly backpressured read of the wrapped block.
    hs_exp[0] = RSP; hs_exp[1] = 32'hB0; hs_exp[2] = 32'hB1; hs_exp[3] = 32'hB2; hs_exp[4] = 32'hB3;
    @(negedge clk);
    rst = 0; in_v = 1; in_dat = rd('h38); out_rdy = 0;
    #1;
    checks++;
    if (o_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hs_accept: rdy=%0b expected 1", o_rdy);
    end
    @(negedge clk);
    in_dat = JUNK;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 60) begin
      out_rdy = (cyc < 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (o_v !== 1'b1 || o_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hs_busy: cycle %0d v=%0b rdy=%0b expected v=1 rdy=0", cyc, o_v, o_rdy);
      end
      if (out_rdy) begin
        checks++;
        if (o_dat !== hs_exp[got]) begin
          errors++;
          $display("FAIL hs_beat[%0d]: dat=%h expected %h", got, o_dat, hs_exp[got]);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (got < 5) begin
      errors++;
      $display("FAIL hs_timeout: %0d beats received, expected 5", got);
    end
    in_v = 0;
    out_rdy = 1;
    #1;
    checks++;
    if (o_v !== 1'b0 || o_rdy !== 1'b1 || o_dat !== '0) begin
      errors++;
      $display("FAIL hs_idle: v=%0b rdy=%0b dat=%h expected v=0 rdy=1 dat=0", o_v, o_rdy, o_dat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
